alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 33 +++
 rtl/alu_seq_regfile.sv | 34 +++
 rtl/alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: state encoding, opcodes and
// instruction field positions. SEQ_SINGLE_STEP_EN adds the HOLD state.
package alu_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
      , S_HOLD = 3'd5
`endif
   } state_t;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   localparam logic [1:0] OP_MOV = 2'd3;

   // Instruction layout: [7:6] opcode, [5:4] rd, [3:2] rs, [3:0] addrs
   localparam int OP_MSB    = 7;
   localparam int OP_LSB    = 6;
   localparam int RD_MSB    = 5;
   localparam int RD_LSB    = 4;
   localparam int RS_MSB    = 3;
   localparam int RS_LSB    = 2;
   localparam int ADDRS_MSB = 3;
   localparam int ADDRS_LSB = 0;

   localparam int NUM_REGS = 4;

endpackage

// File: rtl/alu_seq_regfile.sv
// Four 8-bit registers: two asynchronous read ports, one synchronous write
// port, asynchronous active-high reset to zero. A read of the register being
// written returns the old value until the clock edge.
module alu_seq_regfile
   import alu_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] raddr0,
   output logic [7:0] rdata0,
   input  logic [1:0] raddr1,
   output logic [7:0] rdata1,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [7:0] wdata
);

   logic [7:0] regs [NUM_REGS];

   // Register storage: cleared on reset, single write per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata0 = regs[raddr0];
   assign rdata1 = regs[raddr1];

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: fetches 8-bit instructions, drives an external ALU, performs
// optional data-memory transfers and writes results back to a 4-entry
// register file. Optional macro SEQ_SINGLE_STEP_EN adds a step input and a
// HOLD state so each instruction needs a step rising edge to start.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic       fetch_req,
   output logic [3:0] fetch_addr,
   input  logic       fetch_valid,
   input  logic [7:0] fetch_data,
   output logic [1:0] alu_opcode,
   output logic [3:0] alu_addrs,
   output logic [7:0] alu_din0,
   output logic [7:0] alu_din1,
   input  logic [7:0] alu_dout,
   input  logic       alu_carry,
   input  logic       alu_borrow,
   input  logic       alu_carry_en,
   input  logic       alu_bcf,
   input  logic       alu_mem_write,
   input  logic       alu_mem_read,
   input  logic       alu_toggle,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       toggle_q,
   output logic       busy
);

   state_t     state, state_next;
   logic [3:0] pc;
   logic [7:0] instr;
   logic [7:0] result;
   logic       flag;
   logic       mem_write_lat;
   logic       mem_read_lat;
   logic       toggle_lat;
   logic       bcf_lat;

   logic [1:0] opcode;
   logic [1:0] rd;
   logic [1:0] rs;
   logic [3:0] addrs;
   logic [7:0] rd_data;
   logic [7:0] rs_data;
   logic       wb_write;

   assign opcode = instr[OP_MSB:OP_LSB];
   assign rd     = instr[RD_MSB:RD_LSB];
   assign rs     = instr[RS_MSB:RS_LSB];
   assign addrs  = instr[ADDRS_MSB:ADDRS_LSB];

   // MOV with a memory write is a pure store and leaves rd untouched
   assign wb_write = (opcode != OP_MOV) || !mem_write_lat;

   alu_seq_regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr0 (rd),
      .rdata0 (rd_data),
      .raddr1 (rs),
      .rdata1 (rs_data),
      .we     ((state == S_WB) && wb_write),
      .waddr  (rd),
      .wdata  (result)
   );

   assign fetch_addr = pc;
   assign alu_opcode = opcode;
   assign alu_addrs  = addrs;
   assign alu_din0   = rd_data;
   assign alu_din1   = rs_data;
   assign mem_addr   = rs_data;
   assign mem_wdata  = rd_data;
   assign mem_we     = mem_write_lat;

`ifdef SEQ_SINGLE_STEP_EN
   logic step_prev;
   logic step_rise;

   // Remember last step level so a rising edge can be detected in HOLD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) step_prev <= 1'b0;
      else     step_prev <= step;
   end

   assign step_rise = step & ~step_prev;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_next = state;
      fetch_req  = 1'b0;
      mem_req    = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE:  if (run) state_next = S_FETCH;
         S_FETCH: begin
            fetch_req = 1'b1;
            if (fetch_valid) state_next = S_EXEC;
         end
         S_EXEC:  state_next = (alu_mem_read || alu_mem_write) ? S_MEM : S_WB;
         S_MEM: begin
            mem_req = 1'b1;
            if (mem_ack) state_next = S_WB;
         end
`ifdef SEQ_SINGLE_STEP_EN
         S_WB:    state_next = run ? S_HOLD : S_IDLE;
         S_HOLD: begin
            if (!run)          state_next = S_IDLE;
            else if (step_rise) state_next = S_FETCH;
         end
`else
         S_WB:    state_next = run ? S_FETCH : S_IDLE;
`endif
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: instruction latch, ALU/memory result, flag, strobes, pc
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= '0;
         instr         <= '0;
         result        <= '0;
         flag          <= 1'b0;
         toggle_q      <= 1'b0;
         mem_write_lat <= 1'b0;
         mem_read_lat  <= 1'b0;
         toggle_lat    <= 1'b0;
         bcf_lat       <= 1'b0;
      end else begin
         case (state)
            S_FETCH: if (fetch_valid) instr <= fetch_data;
            S_EXEC: begin
               result        <= alu_dout;
               mem_write_lat <= alu_mem_write;
               mem_read_lat  <= alu_mem_read & ~alu_mem_write;
               toggle_lat    <= alu_toggle;
               bcf_lat       <= alu_bcf;
               if (alu_carry_en) begin
                  if (opcode == OP_ADD)      flag <= alu_carry;
                  else if (opcode == OP_SUB) flag <= alu_borrow;
               end
            end
            S_MEM: if (mem_ack && mem_read_lat) result <= mem_rdata;
            S_WB: begin
               if (toggle_lat) toggle_q <= ~toggle_q;
               pc <= (bcf_lat && flag) ? addrs : pc + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios followed by
// randomized instructions, compared against a behavioural model of the
// register file, pc, flag and toggle pin. Handles SEQ_SINGLE_STEP_EN builds.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst, run, step;
   logic       fetch_req, fetch_valid;
   logic [3:0] fetch_addr;
   logic [7:0] fetch_data;
   logic [1:0] alu_opcode;
   logic [3:0] alu_addrs;
   logic [7:0] alu_din0, alu_din1, alu_dout;
   logic       alu_carry, alu_borrow, alu_carry_en, alu_bcf;
   logic       alu_mem_write, alu_mem_read, alu_toggle;
   logic       mem_req, mem_we, mem_ack;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       toggle_q, busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mregs [4];
   logic [3:0] mpc;
   logic       mflag, mtog;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst(rst), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .alu_opcode(alu_opcode), .alu_addrs(alu_addrs),
      .alu_din0(alu_din0), .alu_din1(alu_din1), .alu_dout(alu_dout),
      .alu_carry(alu_carry), .alu_borrow(alu_borrow),
      .alu_carry_en(alu_carry_en), .alu_bcf(alu_bcf),
      .alu_mem_write(alu_mem_write), .alu_mem_read(alu_mem_read),
      .alu_toggle(alu_toggle),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .toggle_q(toggle_q), .busy(busy)
   );

   // Stand-in for the external ALU: arithmetic on whatever the DUT presents
   always_comb begin
      alu_dout   = 8'h00;
      alu_carry  = 1'b0;
      alu_borrow = 1'b0;
      case (alu_opcode)
         2'd0: {alu_carry, alu_dout} = {1'b0, alu_din0} + {1'b0, alu_din1};
         2'd1: begin
            alu_dout   = alu_din0 - alu_din1;
            alu_borrow = (alu_din0 < alu_din1);
         end
         2'd2: alu_dout = alu_din0 ^ alu_din1;
         default: alu_dout = alu_din1;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
      mpc   = 4'h0;
      mflag = 1'b0;
      mtog  = 1'b0;
   endtask

   task automatic wait_fetch();
      int i = 0;
      while (!fetch_req && i < 50) begin
         @(negedge clk);
         i++;
      end
      check("fetch_req_seen", fetch_req, 1);
   endtask

   // One complete instruction: fetch, exec, optional memory, writeback
   task automatic run_instr(input logic [7:0] ins, input bit rd_s, input bit wr_s,
                            input bit cen, input bit bcf, input bit tog,
                            input int fdly, input int mdly, input logic [7:0] rdata,
                            input bit drop_run, input bit stop_in_mem);
      logic [1:0] op, rd, rs;
      logic [3:0] ad;
      logic [7:0] a, b, res;
      int s;
      op = ins[7:6]; rd = ins[5:4]; rs = ins[3:2]; ad = ins[3:0];
      wait_fetch();
      check("fetch_addr", fetch_addr, mpc);
      check("fetch_mem_excl", mem_req, 0);
      repeat (fdly) @(negedge clk);
      fetch_valid = 1'b1; fetch_data = ins;
      alu_carry_en = cen; alu_bcf = bcf; alu_toggle = tog;
      alu_mem_read = rd_s; alu_mem_write = wr_s;
      @(negedge clk);
      fetch_valid = 1'b0; fetch_data = 8'($urandom);
      a = mregs[rd]; b = mregs[rs];
      check("exec_opcode", alu_opcode, op);
      check("exec_addrs", alu_addrs, ad);
      check("exec_din0", alu_din0, a);
      check("exec_din1", alu_din1, b);
      check("exec_no_req", {fetch_req, mem_req}, 0);
      if (drop_run) run = 1'b0;
      // Reference result and flag from plain arithmetic
      res = 8'h00;
      case (op)
         2'd0: begin
            s = int'(a) + int'(b);
            res = 8'(s % 256);
            if (cen) mflag = (s > 255);
         end
         2'd1: begin
            s = int'(a) - int'(b);
            res = 8'((s + 256) % 256);
            if (cen) mflag = (s < 0);
         end
         2'd2: res = a ^ b;
         default: res = b;
      endcase
      @(negedge clk);
      alu_carry_en = 0; alu_bcf = 0; alu_toggle = 0; alu_mem_read = 0; alu_mem_write = 0;
      if (rd_s || wr_s) begin
         check("mem_req_start", mem_req, 1);
         check("mem_we", mem_we, wr_s);
         check("mem_addr", mem_addr, b);
         check("mem_wdata", mem_wdata, a);
         if (stop_in_mem) return;
         for (int i = 0; i < mdly; i++) begin
            check("mem_req_hold", mem_req, 1);
            check("mem_no_fetch", fetch_req, 0);
            check("mem_addr_stable", mem_addr, b);
            if (i == mdly - 1) begin
               mem_ack = 1'b1; mem_rdata = rdata;
            end
            @(negedge clk);
         end
         mem_ack = 1'b0; mem_rdata = 8'($urandom);
         if (rd_s) res = rdata;
      end
      check("wb_busy", busy, 1);
      check("wb_no_req", {fetch_req, mem_req}, 0);
      if (op != 2'd3 || !wr_s) mregs[rd] = res;
      if (tog) mtog = ~mtog;
      mpc = (bcf && mflag) ? ad : mpc + 4'd1;
      @(negedge clk);
      check("toggle_q", toggle_q, mtog);
      if (!run) begin
         check("idle_busy", busy, 0);
         check("idle_no_fetch", fetch_req, 0);
      end
`ifdef SEQ_SINGLE_STEP_EN
      else begin
         @(negedge clk);
         check("hold_no_fetch", fetch_req, 0);
         check("hold_busy", busy, 1);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
      end
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; run = 0; step = 0; fetch_valid = 0; fetch_data = 0;
      mem_ack = 0; mem_rdata = 0;
      alu_carry_en = 0; alu_bcf = 0; alu_toggle = 0; alu_mem_read = 0; alu_mem_write = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_reqs", {fetch_req, mem_req}, 0);
      check("rst_toggle", toggle_q, 0);
      check("rst_fetch_addr", fetch_addr, 0);
      rst = 0;
      @(negedge clk);
      check("idle_without_run", busy, 0);
      run = 1;
      @(negedge clk);
      check("busy_2nd_cycle", busy, 1);

      // add r0,r1 with zeros, then pc must advance to 1
      run_instr(8'h04, 0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
      wait_fetch();
      check("addr_after_first", fetch_addr, 4'h1);
      // load r0=FF, r1=01, add with carry, branch on flag to A
      run_instr(8'hC0, 1, 0, 0, 0, 0, 1, 1, 8'hFF, 0, 0);
      run_instr(8'hD0, 1, 0, 0, 0, 0, 0, 1, 8'h01, 0, 0);
      run_instr(8'h04, 0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
      run_instr(8'hBA, 0, 0, 0, 1, 0, 0, 1, 8'h00, 0, 0);
      wait_fetch();
      check("branch_target", fetch_addr, 4'hA);
      // branch to F, then a plain instruction must wrap pc to 0
      run_instr(8'h8F, 0, 0, 0, 1, 1, 0, 1, 8'h00, 0, 0);
      run_instr(8'h2C, 0, 0, 0, 0, 0, 2, 1, 8'h00, 0, 0);
      wait_fetch();
      check("pc_wrap", fetch_addr, 4'h0);
      // memory read with 5-cycle ack latency, then read back r2
      run_instr(8'hE4, 1, 0, 0, 0, 0, 0, 5, 8'h5A, 0, 0);
      run_instr(8'h28, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
      // store via MOV must not write rd
      run_instr(8'hF4, 0, 1, 0, 0, 0, 0, 2, 8'h00, 0, 0);
      // run dropped in EXEC: finish instruction, then idle
      run_instr(8'h44, 0, 0, 1, 0, 0, 0, 1, 8'h00, 1, 0);
      repeat (3) @(negedge clk);
      check("stay_idle", fetch_req, 0);
      run = 1;

      for (int n = 0; n < 120; n++) begin
         int kind;
         bit rs_b, ws_b;
         kind = int'($urandom_range(0, 7));
         rs_b = (kind == 0);
         ws_b = (kind == 1);
         run_instr(8'($urandom), rs_b, ws_b, 1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 3)), 8'($urandom), 0, 0);
      end

      // reset while a memory transfer is pending
      if (!mtog) run_instr(8'h00, 0, 0, 0, 0, 1, 0, 1, 8'h00, 0, 0);
      run_instr(8'hC5, 1, 0, 0, 0, 0, 0, 3, 8'h33, 0, 1);
      #2 rst = 1;
      #1;
      check("rst_mem_busy", busy, 0);
      check("rst_mem_reqs", {fetch_req, mem_req}, 0);
      check("rst_mem_toggle", toggle_q, 0);
      check("rst_mem_pc", fetch_addr, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
      wait_fetch();
      check("first_fetch_after_rst", fetch_addr, 4'h0);
      run_instr(8'h04, 0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
